// File: rtl/reservoir_sequencer.sv
// Reservoir-computing virtual-node sequencer: accepts samples, sweeps the node chain, hands out readouts.
// Optional abort input is compiled in when RESERVOIR_SEQ_ABORT_EN is defined.
module reservoir_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODES  = 16,
  localparam int IW        = $clog2(NUM_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           num_samples,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  node_en,
  output logic                  node_load,
  output logic [IW-1:0]         node_idx,
  output logic                  readout_valid,
  input  logic                  readout_ready,
`ifdef RESERVOIR_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic [15:0]           sample_idx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_RUN, S_READOUT, S_FINISH
  } state_t;

  localparam logic [IW-1:0] LAST_NODE = IW'(NUM_NODES - 1);

  state_t      state, state_nxt;
  logic [15:0] num_q;
  logic        abort_req;
  logic        last_sample;
  logic        node_last;

`ifdef RESERVOIR_SEQ_ABORT_EN
  // FINISH already ends the run, so an abort there changes nothing.
  assign abort_req = abort && (state != S_IDLE) && (state != S_FINISH);
`else
  assign abort_req = 1'b0;
`endif

  assign last_sample = (sample_idx == (num_q - 16'd1));
  assign node_last   = (node_idx == LAST_NODE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = (num_q == 16'd0) ? S_FINISH : S_WAIT;
      S_WAIT:    if (sample_valid) state_nxt = S_RUN;
      S_RUN:     if (node_last) state_nxt = S_READOUT;
      S_READOUT: if (readout_ready) state_nxt = last_sample ? S_FINISH : S_WAIT;
      S_FINISH:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort_req) state_nxt = S_FINISH;
  end

  always_comb begin
    sample_ready  = (state == S_WAIT);
    node_load     = (state == S_LOAD);
    node_en       = (state == S_RUN);
    readout_valid = (state == S_READOUT);
    done          = (state == S_FINISH);
    busy          = (state != S_IDLE);
  end

  // Run bookkeeping and the sample register; an abort suppresses any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q      <= '0;
      sample_idx <= '0;
      node_idx   <= '0;
      sample_out <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        num_q      <= num_samples;
        sample_idx <= '0;
      end
      if (state == S_READOUT && readout_ready && !last_sample && !abort_req)
        sample_idx <= sample_idx + 16'd1;
      if (state == S_WAIT && sample_valid && !abort_req)
        sample_out <= sample_data;
      node_idx <= (state == S_RUN && state_nxt == S_RUN) ? node_idx + IW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Self-checking bench for reservoir_sequencer (NUM_NODES=4) with randomized handshake timing.
module tb_reservoir_sequencer;

  localparam int DW = 32;
  localparam int NN = 4;

  localparam logic [5:0] F_IDLE = 6'b000000;
  localparam logic [5:0] F_LOAD = 6'b001010;
  localparam logic [5:0] F_WAIT = 6'b100010;
  localparam logic [5:0] F_RUN  = 6'b010010;
  localparam logic [5:0] F_RDO  = 6'b000110;
  localparam logic [5:0] F_FIN  = 6'b000011;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   num_samples = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [DW-1:0] sample_data = '0;
  logic [DW-1:0] sample_out;
  logic          node_en, node_load;
  logic [1:0]    node_idx;
  logic          readout_valid;
  logic          readout_ready = 1'b0;
  logic [15:0]   sample_idx;
  logic          busy, done;
`ifdef RESERVOIR_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_out = '0;
  logic [DW-1:0] data_q[$];
  logic [5:0]    flags;

  assign flags = {sample_ready, node_en, node_load, readout_valid, busy, done};

  reservoir_sequencer #(.DATA_WIDTH(DW), .NUM_NODES(NN)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .sample_out(sample_out), .node_en(node_en), .node_load(node_load), .node_idx(node_idx),
    .readout_valid(readout_valid), .readout_ready(readout_ready),
`ifdef RESERVOIR_SEQ_ABORT_EN
    .abort(abort),
`endif
    .sample_idx(sample_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({flags, node_idx, sample_idx} !== {F_IDLE, 2'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_ctrl got %h exp %h", {flags, node_idx, sample_idx}, {F_IDLE, 2'd0, 16'd0});
    end
    checks++;
    if (sample_out !== '0) begin
      errors++;
      $display("FAIL reset_out got %h exp 0", sample_out);
    end
    exp_out = '0;
  endtask

  // Full run; vdly/rdly < 0 pick a random delay per sample.
  task automatic test_run(input int n, input int vdly, input int rdly);
    logic [DW-1:0] d;
    int dv, dr;
    start = 1'b1;
    num_samples = 16'(n);
    tick();
    start = 1'b0;
    num_samples = 16'($urandom);
    checks++;
    if ({flags, node_idx, sample_idx} !== {F_LOAD, 2'd0, 16'd0}) begin
      errors++;
      $display("FAIL load got %h exp %h", {flags, node_idx, sample_idx}, {F_LOAD, 2'd0, 16'd0});
    end
    tick();
    for (int s = 0; s < n; s++) begin
      d  = (data_q.size() > 0) ? data_q.pop_front() : DW'($urandom);
      dv = (vdly < 0) ? int'($urandom_range(0, 3)) : vdly;
      dr = (rdly < 0) ? int'($urandom_range(0, 3)) : rdly;
      sample_data = DW'($urandom);
      for (int k = 0; k <= dv; k++) begin
        checks++;
        if ({flags, node_idx, sample_idx} !== {F_WAIT, 2'd0, 16'(s)}) begin
          errors++;
          $display("FAIL wait got %h exp %h", {flags, node_idx, sample_idx}, {F_WAIT, 2'd0, 16'(s)});
        end
        checks++;
        if (sample_out !== exp_out) begin
          errors++;
          $display("FAIL wait_out got %h exp %h", sample_out, exp_out);
        end
        if (k == dv) begin
          sample_valid = 1'b1;
          sample_data  = d;
        end
        tick();
      end
      sample_valid = 1'b0;
      sample_data  = DW'($urandom);
      exp_out      = d;
      for (int k = 0; k < NN; k++) begin
        checks++;
        if ({flags, node_idx, sample_idx} !== {F_RUN, 2'(k), 16'(s)}) begin
          errors++;
          $display("FAIL run got %h exp %h", {flags, node_idx, sample_idx}, {F_RUN, 2'(k), 16'(s)});
        end
        checks++;
        if (sample_out !== exp_out) begin
          errors++;
          $display("FAIL run_out got %h exp %h", sample_out, exp_out);
        end
        tick();
      end
      for (int k = 0; k <= dr; k++) begin
        checks++;
        if ({flags, node_idx, sample_idx} !== {F_RDO, 2'd0, 16'(s)}) begin
          errors++;
          $display("FAIL readout got %h exp %h", {flags, node_idx, sample_idx}, {F_RDO, 2'd0, 16'(s)});
        end
        if (k == dr) readout_ready = 1'b1;
        tick();
      end
      readout_ready = 1'b0;
    end
    checks++;
    if ({flags, node_idx, sample_idx} !== {F_FIN, 2'd0, 16'((n == 0) ? 0 : n - 1)}) begin
      errors++;
      $display("FAIL finish got %h exp %h", {flags, node_idx, sample_idx},
               {F_FIN, 2'd0, 16'((n == 0) ? 0 : n - 1)});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (flags !== F_IDLE) begin
        errors++;
        $display("FAIL idle_after got %b exp %b", flags, F_IDLE);
      end
      checks++;
      if (sample_out !== exp_out) begin
        errors++;
        $display("FAIL idle_out got %h exp %h", sample_out, exp_out);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    data_q.push_back(32'hA5);
    data_q.push_back(32'h3C);
    test_run(2, 0, 0);
  endtask

  task automatic test_zero_samples();
    test_run(0, 0, 0);
  endtask

  task automatic test_backpressure();
    test_run(2, 0, 5);
  endtask

  task automatic test_valid_delay();
    test_run(1, 7, 0);
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    num_samples = 16'd2;
    tick();
    start = 1'b0;
    tick();
    sample_valid = 1'b1;
    sample_data  = 32'hDEAD_BEEF;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({flags, node_idx} !== {F_RUN, 2'd2}) begin
      errors++;
      $display("FAIL rst_run3 got %h exp %h", {flags, node_idx}, {F_RUN, 2'd2});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({flags, node_idx, sample_idx, sample_out} !== {F_IDLE, 2'd0, 16'd0, 32'd0}) begin
      errors++;
      $display("FAIL rst_mid got %h exp 0", {flags, node_idx, sample_idx, sample_out});
    end
    exp_out = '0;
    test_run(2, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) test_run(int'($urandom_range(1, 4)), -1, -1);
  endtask

`ifdef RESERVOIR_SEQ_ABORT_EN
  task automatic test_abort();
    start = 1'b1;
    num_samples = 16'd3;
    tick();
    start = 1'b0;
    tick();
    sample_valid = 1'b1;
    sample_data  = 32'h1234_5678;
    tick();
    sample_valid = 1'b0;
    tick();
    checks++;
    if ({flags, node_idx} !== {F_RUN, 2'd1}) begin
      errors++;
      $display("FAIL abort_run2 got %h exp %h", {flags, node_idx}, {F_RUN, 2'd1});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({flags, node_idx} !== {F_FIN, 2'd0}) begin
      errors++;
      $display("FAIL abort_fin got %h exp %h", {flags, node_idx}, {F_FIN, 2'd0});
    end
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    checks++;
    if (flags !== F_IDLE) begin
      errors++;
      $display("FAIL abort_idle got %b exp %b", flags, F_IDLE);
    end
    exp_out = 32'h1234_5678;
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_basic();
    test_zero_samples();
    test_backpressure();
    test_valid_delay();
    test_reset_mid_run();
    test_random();
`ifdef RESERVOIR_SEQ_ABORT_EN
    test_abort();
    test_run(2, -1, -1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservoir_sequencer.md
RESERVOIR_SEQUENCER -- requirements
Module: reservoir_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the sample and node data.
REQ-002 SHALL have parameter NUM_NODES, default 16, virtual nodes per sample (>=2); IW = $clog2(NUM_NODES).
REQ-003 SHALL have port clk, input, 1: clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: begin a run; sampled only in IDLE.
REQ-006 SHALL have port num_samples, input, 16: samples per run; latched on accepted start.
REQ-007 SHALL have ports sample_valid (input, 1), sample_ready (output, 1) and sample_data (input, DATA_WIDTH): input sample stream.
REQ-008 SHALL have port sample_out, output, DATA_WIDTH: registered copy of the last accepted sample, feeding the node chain.
REQ-009 SHALL have ports node_en (output, 1), node_load (output, 1) and node_idx (output, IW): node chain shift enable, chain preload strobe and current virtual-node index.
REQ-010 SHALL have ports readout_valid (output, 1) and readout_ready (input, 1): per-sample reservoir-state readout handshake.
REQ-011 SHALL have port sample_idx, output, 16: index of the sample being processed.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1): busy is high whenever state != IDLE; done is a 1-cycle end-of-run pulse.

Function
REQ-013 SHALL implement the states IDLE, LOAD, WAIT, RUN, READOUT and FINISH.
REQ-014 SHALL move IDLE->LOAD on the first cycle start=1, latch num_samples and clear sample_idx; start SHALL be ignored in every other state.
REQ-015 SHALL drive node_load=1 for exactly one cycle in LOAD; LOAD SHALL go to FINISH if the latched num_samples==0, otherwise to WAIT.
REQ-016 SHALL hold sample_ready=1 only in WAIT; on sample_valid&&sample_ready, sample_data SHALL register into sample_out and the state SHALL go to RUN next cycle.
REQ-017 SHALL hold node_en=1 in RUN for exactly NUM_NODES consecutive cycles, with node_idx counting 0..NUM_NODES-1, then go to READOUT.
REQ-018 SHALL hold node_idx at 0 outside RUN, and node_en and node_load SHALL never be high in the same cycle.
REQ-019 SHALL hold readout_valid=1 in READOUT until readout_ready=1; sample_idx SHALL stay stable while readout_valid=1 (backpressure, no shifting).
REQ-020 SHALL, on the READOUT handshake, go to FINISH if sample_idx==num_samples-1, else increment sample_idx and return to WAIT.
REQ-021 SHALL assert done=1 for one cycle in FINISH, then return to IDLE; a start in the FINISH cycle SHALL be ignored.
REQ-022 SHALL hold sample_out unchanged except on the WAIT handshake.
REQ-023 SHALL have a latency from the sample handshake to readout_valid of exactly NUM_NODES+1 cycles.

Reset
REQ-024 SHALL, with rst=1 in any state including mid-RUN, next cycle be in IDLE with sample_ready, node_en, node_load, readout_valid, busy and done all 0, and node_idx, sample_idx and sample_out all 0.
REQ-025 SHALL give rst priority over start, sample handshake, readout handshake and abort.

Configuration
REQ-026 SHALL, when macro RESERVOIR_SEQ_ABORT_EN is defined, add an input port abort (1 bit); abort=1 in any non-IDLE state SHALL force FINISH next cycle (done pulses, node_en drops immediately), with no further samples accepted.
REQ-027 SHALL, without RESERVOIR_SEQ_ABORT_EN, have no abort port, and every run SHALL complete all latched samples.

Verification (NUM_NODES=4, DATA_WIDTH=32)
REQ-028 SHALL cover: start, num_samples=2, samples 0xA5 then 0x3C, readout_ready=1 -> node_load 1 cycle; for each sample node_en 4 cycles with node_idx 0,1,2,3; readout_valid with sample_idx 0 then 1; done 1 cycle; busy low after.
REQ-029 SHALL cover: num_samples=0 -> LOAD then done 1 cycle, no sample_ready, no node_en.
REQ-030 SHALL cover: readout_ready held 0 for 5 cycles -> readout_valid stays 1, sample_idx stable, sample_ready 0 and node_en 0 throughout.
REQ-031 SHALL cover: sample_valid delayed 7 cycles in WAIT -> sample_ready stays 1, node_en 0; RUN begins the cycle after the handshake.
REQ-032 SHALL cover: rst asserted on the 3rd RUN cycle -> all outputs 0 next cycle; a new start then runs normally from sample_idx 0.
REQ-033 SHALL cover, with RESERVOIR_SEQ_ABORT_EN: abort on the 2nd RUN cycle of sample 0 of 3 -> node_en 0 next cycle, done pulse, IDLE after.
